// File: rtl/waka_pkg.sv
// Shared constants and types for the hls_macc operand feeder.
// WAKA_FEEDER_SEED_EN is consumed by waka_macc_feeder.
package waka_pkg;

   localparam int unsigned DW     = 32;
   localparam int unsigned N_OPS  = 20;
   localparam int unsigned N_RES  = 4;
   // One extra code point so the operand counter can address the seed slot.
   localparam int unsigned OP_AW  = $clog2(N_OPS + 1);
   localparam int unsigned RES_AW = $clog2(N_RES);

   typedef enum logic [1:0] {LOAD, RUN, DRAIN, EMIT} feeder_state_e;

   localparam int unsigned OP_IN1  = 0;
   localparam int unsigned OP_IN2  = 1;
   localparam int unsigned OP_IN3  = 2;
   localparam int unsigned OP_IN4  = 3;
   localparam int unsigned OP_IN7  = 4;
   localparam int unsigned OP_IN8  = 5;
   localparam int unsigned OP_IN9  = 6;
   localparam int unsigned OP_IN10 = 7;
   localparam int unsigned OP_IN14 = 8;
   localparam int unsigned OP_IN12 = 9;
   localparam int unsigned OP_IN15 = 10;
   localparam int unsigned OP_IN17 = 11;
   localparam int unsigned OP_IN19 = 12;
   localparam int unsigned OP_IN20 = 13;
   localparam int unsigned OP_IN22 = 14;
   localparam int unsigned OP_IN24 = 15;
   localparam int unsigned OP_IN27 = 16;
   localparam int unsigned OP_IN28 = 17;
   localparam int unsigned OP_IN29 = 18;
   localparam int unsigned OP_IN32 = 19;

   localparam int unsigned RES_RET = 0;
   localparam int unsigned RES_13  = 1;
   localparam int unsigned RES_30  = 2;
   localparam int unsigned RES_31  = 3;

endpackage

// File: rtl/waka_operand_bank.sv
// N_OPS x DW operand register file: single indexed write port, flat parallel read.
module waka_operand_bank
   import waka_pkg::*;
(
   input  logic                ap_clk,
   input  logic                ap_rst,
   input  logic                we,
   input  logic [OP_AW-1:0]    waddr,
   input  logic [DW-1:0]       wdata,
   output logic [N_OPS*DW-1:0] rdata
);

   logic [DW-1:0] mem_q [N_OPS];

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int i = 0; i < int'(N_OPS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && (waddr < OP_AW'(N_OPS))) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < int'(N_OPS); i++) begin
         rdata[i*DW +: DW] = mem_q[i];
      end
   end

endmodule

// File: rtl/waka_macc_feeder.sv
// Serial operand loader, ap_start/ap_done sequencer and result streamer for hls_macc.
// Optional WAKA_FEEDER_SEED_EN: a 21st load word seeds the out30 state register.
module waka_macc_feeder
   import waka_pkg::*;
(
   input  logic                ap_clk,
   input  logic                ap_rst,
   input  logic [DW-1:0]       s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [DW-1:0]       m_data,
   output logic                m_valid,
   output logic                m_last,
   input  logic                m_ready,
   output logic                k_ap_start,
   input  logic                k_ap_done,
   input  logic                k_ap_idle,
   output logic [N_OPS*DW-1:0] k_in,
   input  logic [DW-1:0]       k_out13,
   input  logic                k_out13_vld,
   output logic [DW-1:0]       k_out30_i,
   input  logic [DW-1:0]       k_out30_o,
   input  logic                k_out30_vld,
   input  logic [DW-1:0]       k_out31,
   input  logic                k_out31_vld,
   input  logic [DW-1:0]       k_return,
   output logic                busy
);

`ifdef WAKA_FEEDER_SEED_EN
   localparam int unsigned LAST_OP = N_OPS;
`else
   localparam int unsigned LAST_OP = N_OPS - 1;
`endif

   feeder_state_e     state_q, state_d;
   logic [OP_AW-1:0]  op_cnt_q;
   logic [RES_AW-1:0] res_cnt_q;
   logic [DW-1:0]     out30_q, res13_q, res31_q, ret_q;
   logic              s_hs, m_hs, op_last, res_last, bank_we;

   // Idle is status only; the one-cycle DRAIN already guarantees the kernel re-arms.
   logic unused_idle;
   assign unused_idle = k_ap_idle;

   assign s_hs     = s_valid && s_ready;
   assign m_hs     = m_valid && m_ready;
   assign op_last  = (op_cnt_q == OP_AW'(LAST_OP));
   assign res_last = (res_cnt_q == RES_AW'(N_RES - 1));
   assign bank_we  = s_hs && (op_cnt_q < OP_AW'(N_OPS));

   waka_operand_bank u_bank (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .we     (bank_we),
      .waddr  (op_cnt_q),
      .wdata  (s_data),
      .rdata  (k_in)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:  if (s_hs && op_last) state_d = RUN;
         RUN:   if (k_ap_done) state_d = DRAIN;
         DRAIN: state_d = EMIT;
         EMIT:  if (m_hs && res_last) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q   <= LOAD;
         op_cnt_q  <= '0;
         res_cnt_q <= '0;
         out30_q   <= '0;
         res13_q   <= '0;
         res31_q   <= '0;
         ret_q     <= '0;
      end else begin
         state_q <= state_d;
         if (s_hs) begin
            op_cnt_q <= op_last ? '0 : op_cnt_q + 1'b1;
         end
         if (m_hs) begin
            res_cnt_q <= res_last ? '0 : res_cnt_q + 1'b1;
         end
         if (state_q == RUN) begin
            if (k_out13_vld) res13_q <= k_out13;
            if (k_out30_vld) out30_q <= k_out30_o;
            if (k_out31_vld) res31_q <= k_out31;
            if (k_ap_done)   ret_q   <= k_return;
         end
`ifdef WAKA_FEEDER_SEED_EN
         if (s_hs && (op_cnt_q == OP_AW'(N_OPS))) begin
            out30_q <= s_data;
         end
`endif
      end
   end

   always_comb begin
      s_ready    = (state_q == LOAD);
      m_valid    = (state_q == EMIT);
      m_last     = m_valid && res_last;
      k_ap_start = (state_q == RUN);
      busy       = (state_q != LOAD);
      k_out30_i  = out30_q;
      m_data     = '0;
      unique case (res_cnt_q)
         RES_AW'(RES_RET): m_data = ret_q;
         RES_AW'(RES_13):  m_data = res13_q;
         RES_AW'(RES_30):  m_data = out30_q;
         RES_AW'(RES_31):  m_data = res31_q;
         default:          m_data = '0;
      endcase
   end

endmodule

// File: tb/tb_waka_macc_feeder.sv
// Directed bench for waka_macc_feeder with a small behavioural hls_macc stand-in.
module tb_waka_macc_feeder;
   import waka_pkg::*;

   logic                ap_clk = 1'b0;
   logic                ap_rst;
   logic [DW-1:0]       s_data;
   logic                s_valid, s_ready;
   logic [DW-1:0]       m_data;
   logic                m_valid, m_last, m_ready;
   logic                k_ap_start, k_ap_done, k_ap_idle;
   logic [N_OPS*DW-1:0] k_in;
   logic [DW-1:0]       k_out13, k_out30_i, k_out30_o, k_out31, k_return;
   logic                k_out13_vld, k_out30_vld, k_out31_vld;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int start_cyc = 0;
   int drain_cyc = 0;

   always #5 ap_clk = ~ap_clk;

   waka_macc_feeder dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_last      (m_last),
      .m_ready     (m_ready),
      .k_ap_start  (k_ap_start),
      .k_ap_done   (k_ap_done),
      .k_ap_idle   (k_ap_idle),
      .k_in        (k_in),
      .k_out13     (k_out13),
      .k_out13_vld (k_out13_vld),
      .k_out30_i   (k_out30_i),
      .k_out30_o   (k_out30_o),
      .k_out30_vld (k_out30_vld),
      .k_out31     (k_out31),
      .k_out31_vld (k_out31_vld),
      .k_return    (k_return),
      .busy        (busy)
   );

   // Kernel stand-in: equal in1/in2 is a 4-cycle path that reads out30_i, otherwise a
   // 6-cycle path that overwrites out30 first. ret = out13 + out30 + out31.
   int           kst, kcnt, klat;
   logic         kslow;
   logic [31:0]  kr13, kr30, kr31;

   function automatic logic [31:0] opw(input int unsigned i);
      return k_in[i*DW +: DW];
   endfunction

   assign k_out13   = kr13;
   assign k_out30_o = kr30;
   assign k_out31   = kr31;
   assign k_return  = kr13 + kr30 + kr31;
   assign k_ap_idle = (kst == 0);

   always @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         kst <= 0; kcnt <= 0; klat <= 4; kslow <= 1'b0;
         kr13 <= '0; kr30 <= '0; kr31 <= '0;
         k_ap_done <= 1'b0; k_out13_vld <= 1'b0; k_out30_vld <= 1'b0; k_out31_vld <= 1'b0;
      end else begin
         k_ap_done <= 1'b0; k_out13_vld <= 1'b0; k_out30_vld <= 1'b0; k_out31_vld <= 1'b0;
         case (kst)
            0: if (k_ap_start) begin
               kst   <= 1;
               kcnt  <= 1;
               kr13  <= opw(OP_IN14) - opw(OP_IN15);
               if (opw(OP_IN1) != opw(OP_IN2)) begin
                  kslow <= 1'b1;
                  klat  <= 6;
                  kr30  <= opw(OP_IN9) * opw(OP_IN10) + opw(OP_IN3) - opw(OP_IN4);
                  kr31  <= opw(OP_IN32) + opw(OP_IN19) * opw(OP_IN20) + opw(OP_IN29)
                           - opw(OP_IN28);
               end else begin
                  kslow <= 1'b0;
                  klat  <= 4;
                  kr30  <= k_out30_i;
                  kr31  <= opw(OP_IN32) + opw(OP_IN7) * opw(OP_IN12)
                           + opw(OP_IN8) * opw(OP_IN17);
               end
            end
            1: begin
               kcnt <= kcnt + 1;
               if (kcnt == klat - 1) begin
                  kst         <= 2;
                  k_ap_done   <= 1'b1;
                  k_out13_vld <= 1'b1;
                  k_out31_vld <= 1'b1;
                  k_out30_vld <= kslow;
               end
            end
            default: if (!k_ap_start) kst <= 0;
         endcase
      end
   end

   always @(negedge ap_clk) begin
      if (k_ap_start) start_cyc <= start_cyc + 1;
      if (busy && !k_ap_start && !m_valid) drain_cyc <= drain_cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit stall);
      int t;
      if (stall && ($urandom_range(0, 1) == 1)) begin
         s_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge ap_clk);
         #1;
      end
      s_data  = w;
      s_valid = 1'b1;
      t = 0;
      while (!s_ready && t < 200) begin
         @(posedge ap_clk); #1; t++;
      end
      if (!s_ready) begin
         check_eq("s_ready_timeout", 32'(s_ready), 32'd1);
         s_valid = 1'b0;
         return;
      end
      @(posedge ap_clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic send_ops(input logic [31:0] ops [N_OPS], input logic [31:0] seed,
                           input bit stall);
      for (int i = 0; i < int'(N_OPS); i++) send_word(ops[i], stall);
`ifdef WAKA_FEEDER_SEED_EN
      send_word(seed, stall);
`else
      if (seed != 0) $display("note: seed %0d ignored in this build", seed);
`endif
   endtask

   task automatic recv_res(input logic [31:0] exp [N_RES], input bit stall, input string tag);
      int t;
      logic [31:0] hold;
      for (int i = 0; i < int'(N_RES); i++) begin
         t = 0;
         while (!m_valid && t < 200) begin
            @(posedge ap_clk); #1; t++;
         end
         if (!m_valid) begin
            check_eq($sformatf("%s_m_valid_timeout", tag), 32'(m_valid), 32'd1);
            return;
         end
         if (stall && ($urandom_range(0, 1) == 1)) begin
            m_ready = 1'b0;
            hold = m_data;
            repeat ($urandom_range(1, 3)) @(posedge ap_clk);
            #1;
            check_eq($sformatf("%s_stable%0d", tag, i), m_data, hold);
         end
         m_ready = 1'b1;
         check_eq($sformatf("%s_w%0d", tag, i), m_data, exp[i]);
         check_eq($sformatf("%s_last%0d", tag, i), 32'(m_last), 32'(i == int'(N_RES) - 1));
         @(posedge ap_clk); #1;
         m_ready = 1'b0;
      end
      check_eq($sformatf("%s_done_m_valid", tag), 32'(m_valid), 32'd0);
      check_eq($sformatf("%s_done_busy", tag), 32'(busy), 32'd0);
   endtask

   task automatic run_txn(input logic [31:0] ops [N_OPS], input logic [31:0] seed,
                          input logic [31:0] exp [N_RES], input int exp_start,
                          input bit stall, input string tag);
      int s0, d0;
      s0 = start_cyc;
      d0 = drain_cyc;
      send_ops(ops, seed, stall);
      recv_res(exp, stall, tag);
      check_eq($sformatf("%s_start_cycles", tag), 32'(start_cyc - s0), 32'(exp_start));
      check_eq($sformatf("%s_drain_cycles", tag), 32'(drain_cyc - d0), 32'd1);
   endtask

   logic [31:0] v_fast [N_OPS];
   logic [31:0] v_slow [N_OPS];
   logic [31:0] r_fast [N_RES];
   logic [31:0] r_slow [N_RES];
   logic [31:0] r_seed [N_RES];

   initial begin
      int t;
      ap_rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      for (int i = 0; i < int'(N_OPS); i++) begin
         v_fast[i] = '0;
         v_slow[i] = '0;
      end
      v_fast[OP_IN1] = 5;  v_fast[OP_IN2] = 5;   v_fast[OP_IN7] = 1;  v_fast[OP_IN12] = 2;
      v_fast[OP_IN8] = 3;  v_fast[OP_IN17] = 1;  v_fast[OP_IN32] = 10;
      v_fast[OP_IN14] = 100; v_fast[OP_IN15] = 40;
      v_slow[OP_IN2] = 1;  v_slow[OP_IN9] = 5;   v_slow[OP_IN10] = 2; v_slow[OP_IN3] = 10;
      v_slow[OP_IN4] = 4;  v_slow[OP_IN19] = 1;  v_slow[OP_IN20] = 2; v_slow[OP_IN28] = 3;
      v_slow[OP_IN29] = 7; v_slow[OP_IN32] = 10; v_slow[OP_IN14] = 100;
      v_slow[OP_IN15] = 40;
      r_fast = '{75, 60, 0, 15};
      r_slow = '{92, 60, 16, 16};
      r_seed = '{82, 60, 7, 15};

      repeat (3) @(posedge ap_clk);
      #1;
      check_eq("rst_s_ready", 32'(s_ready), 32'd1);
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_m_last", 32'(m_last), 32'd0);
      check_eq("rst_k_ap_start", 32'(k_ap_start), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_out30", k_out30_i, 32'd0);
      check_eq("rst_k_in_zero", 32'(k_in == '0), 32'd1);
      ap_rst = 1'b0;
      @(posedge ap_clk); #1;

      run_txn(v_fast, 32'd0, r_fast, 5, 1'b0, "fast");
      check_eq("fast_out30", k_out30_i, 32'd0);
      run_txn(v_slow, 32'd0, r_slow, 7, 1'b1, "slow");
      check_eq("slow_out30", k_out30_i, 32'd16);
      run_txn(v_slow, 32'd0, r_slow, 7, 1'b1, "b2b");
      check_eq("b2b_out30", k_out30_i, 32'd16);

      // Abort a slow run while the kernel is still working.
      send_ops(v_slow, 32'd0, 1'b0);
      t = 0;
      while (!k_ap_start && t < 50) begin
         @(posedge ap_clk); #1; t++;
      end
      check_eq("abort_in_run", 32'(k_ap_start), 32'd1);
      repeat (2) @(posedge ap_clk);
      #3;
      ap_rst = 1'b1;
      #1;
      check_eq("abort_k_ap_start", 32'(k_ap_start), 32'd0);
      check_eq("abort_m_valid", 32'(m_valid), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      check_eq("abort_s_ready", 32'(s_ready), 32'd1);
      check_eq("abort_out30", k_out30_i, 32'd0);
      run_txn(v_fast, 32'd0, r_fast, 5, 1'b0, "post_rst");

`ifdef WAKA_FEEDER_SEED_EN
      run_txn(v_fast, 32'd7, r_seed, 5, 1'b1, "seed");
      check_eq("seed_out30", k_out30_i, 32'd7);
`else
      if (r_seed[0] != 82) $display("note: seed table altered");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
